mem_arb_2p: RTL

- Two-requester round-robin arbiter sharing one 64x16 `memory` instance through its valid/ready handshake.
- Sits between two bus masters (e.g. a DMA engine and a CPU-side port) and the memory slave port.
- Registers the winning request, holds it on the memory side until `ready`, then returns a one-cycle response to the winner.
- Includes a per-transaction timeout so a stalled slave cannot deadlock either requester.

---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/mem_arb_2p_rr_arb2.sv | 42 ++++
 rtl/mem_arb_2p.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the two-port memory arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic GRANT_A = 1'b0;
    localparam logic GRANT_B = 1'b1;

    localparam int DEF_WIDTH   = 16;
    localparam int DEF_DEPTH   = 64;
    localparam int DEF_TIMEOUT = 15;

endpackage

// File: rtl/mem_arb_2p_rr_arb2.sv
// Two-input round-robin grant with a one-bit priority pointer.
// Latency: grant is combinational from req_i; pointer moves on the edge where update_i is high.
// Backpressure: none; the caller decides when a grant is consumed via update_i.
// Ports: clk_i/rst_i clock and async active-high reset; req_i[0]=A, req_i[1]=B;
//        update_i advances the pointer past the current grant; gnt_o one-hot grant.
module rr_arb2 (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req_i,
    input  logic       update_i,
    output logic [1:0] gnt_o
);

    // 0: A wins a tie, 1: B wins a tie
    logic ptr_q, ptr_d;

    always_comb begin
        case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = ptr_q ? 2'b10 : 2'b01;
            default: gnt_o = 2'b00;
        endcase
    end

    // After serving A, favour B next, and vice versa.
    always_comb begin
        ptr_d = ptr_q;
        if (update_i && (gnt_o != 2'b00)) begin
            ptr_d = gnt_o[0];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/mem_arb_2p.sv
// Round-robin arbiter letting two requesters share one memory valid/ready slave port.
// Latency: m_valid_o rises on the sampling edge; requester ready pulses on the edge m_ready_i is seen; 3 cycles minimum.
// Backpressure: holds the request until m_ready_i or TIMEOUT BUSY cycles (then responds with err); requesters wait for ready.
// Ports: a_*/b_* requester sides (valid, wr_rd, addr, wdata in; rdata, ready, err out);
//        m_* memory side (valid, wr_rd, addr, wdata out; rdata, ready in). All outputs registered.
module mem_arb_2p
    import mem_arb_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  a_valid_i,
    input  logic                  a_wr_rd_i,
    input  logic [ADDR_WIDTH-1:0] a_addr_i,
    input  logic [WIDTH-1:0]      a_wdata_i,
    output logic [WIDTH-1:0]      a_rdata_o,
    output logic                  a_ready_o,
    output logic                  a_err_o,
    input  logic                  b_valid_i,
    input  logic                  b_wr_rd_i,
    input  logic [ADDR_WIDTH-1:0] b_addr_i,
    input  logic [WIDTH-1:0]      b_wdata_i,
    output logic [WIDTH-1:0]      b_rdata_o,
    output logic                  b_ready_o,
    output logic                  b_err_o,
    output logic                  m_valid_o,
    output logic                  m_wr_rd_o,
    output logic [ADDR_WIDTH-1:0] m_addr_o,
    output logic [WIDTH-1:0]      m_wdata_o,
    input  logic [WIDTH-1:0]      m_rdata_i,
    input  logic                  m_ready_i
);

    localparam int               CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_e                state_q, state_d;
    logic                  gnt_q, gnt_d;
    logic                  m_valid_q, m_valid_d;
    logic                  m_wr_rd_q, m_wr_rd_d;
    logic [ADDR_WIDTH-1:0] m_addr_q, m_addr_d;
    logic [WIDTH-1:0]      m_wdata_q, m_wdata_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  a_ready_q, a_ready_d, a_err_q, a_err_d;
    logic                  b_ready_q, b_ready_d, b_err_q, b_err_d;
    logic [WIDTH-1:0]      a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;

    logic [1:0]            arb_req, arb_gnt;
    logic                  arb_upd;
    logic                  timeout_hit, resp_fire, resp_err;
    logic [WIDTH-1:0]      resp_rdata;

    // cnt_q counts completed BUSY cycles; this is the last one allowed.
    assign timeout_hit = (cnt_q == CNT_LAST);
    assign resp_fire   = (state_q == BUSY) && (m_ready_i || timeout_hit);
    // m_ready_i takes precedence over a timeout landing on the same edge.
    assign resp_err    = !m_ready_i;
    assign resp_rdata  = (m_ready_i && !m_wr_rd_q) ? m_rdata_i : '0;

    // Requests are only arbitrated in IDLE. In RESP the served port is fed
    // back as a one-hot request so the pointer steps past it.
    always_comb begin
        arb_req = 2'b00;
        case (state_q)
            IDLE:    arb_req = {b_valid_i, a_valid_i};
            RESP:    arb_req = (gnt_q == GRANT_B) ? 2'b10 : 2'b01;
            default: arb_req = 2'b00;
        endcase
    end

    assign arb_upd = (state_q == RESP);

    rr_arb2 u_rr_arb2 (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .req_i    (arb_req),
        .update_i (arb_upd),
        .gnt_o    (arb_gnt)
    );

    // FSM: state register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (arb_gnt != 2'b00) state_d = BUSY;
            BUSY:    if (resp_fire) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM: next values of the registered outputs
    always_comb begin
        gnt_d     = gnt_q;
        m_valid_d = m_valid_q;
        m_wr_rd_d = m_wr_rd_q;
        m_addr_d  = m_addr_q;
        m_wdata_d = m_wdata_q;
        cnt_d     = cnt_q;
        a_ready_d = 1'b0;
        a_err_d   = 1'b0;
        a_rdata_d = a_rdata_q;
        b_ready_d = 1'b0;
        b_err_d   = 1'b0;
        b_rdata_d = b_rdata_q;
        case (state_q)
            IDLE: begin
                cnt_d     = '0;
                m_valid_d = (arb_gnt != 2'b00);
                if (arb_gnt[1]) begin
                    gnt_d     = GRANT_B;
                    m_wr_rd_d = b_wr_rd_i;
                    m_addr_d  = b_addr_i;
                    m_wdata_d = b_wdata_i;
                end else if (arb_gnt[0]) begin
                    gnt_d     = GRANT_A;
                    m_wr_rd_d = a_wr_rd_i;
                    m_addr_d  = a_addr_i;
                    m_wdata_d = a_wdata_i;
                end
            end
            BUSY: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (resp_fire) begin
                    m_valid_d = 1'b0;
                    if (gnt_q == GRANT_B) begin
                        b_ready_d = 1'b1;
                        b_err_d   = resp_err;
                        b_rdata_d = resp_rdata;
                    end else begin
                        a_ready_d = 1'b1;
                        a_err_d   = resp_err;
                        a_rdata_d = resp_rdata;
                    end
                end
            end
            default: begin
                // RESP and any unreachable encoding
                cnt_d     = '0;
                m_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            gnt_q     <= GRANT_A;
            m_valid_q <= 1'b0;
            m_wr_rd_q <= 1'b0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            cnt_q     <= '0;
            a_ready_q <= 1'b0;
            a_err_q   <= 1'b0;
            a_rdata_q <= '0;
            b_ready_q <= 1'b0;
            b_err_q   <= 1'b0;
            b_rdata_q <= '0;
        end else begin
            gnt_q     <= gnt_d;
            m_valid_q <= m_valid_d;
            m_wr_rd_q <= m_wr_rd_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
            cnt_q     <= cnt_d;
            a_ready_q <= a_ready_d;
            a_err_q   <= a_err_d;
            a_rdata_q <= a_rdata_d;
            b_ready_q <= b_ready_d;
            b_err_q   <= b_err_d;
            b_rdata_q <= b_rdata_d;
        end
    end

    assign m_valid_o = m_valid_q;
    assign m_wr_rd_o = m_wr_rd_q;
    assign m_addr_o  = m_addr_q;
    assign m_wdata_o = m_wdata_q;
    assign a_ready_o = a_ready_q;
    assign a_err_o   = a_err_q;
    assign a_rdata_o = a_rdata_q;
    assign b_ready_o = b_ready_q;
    assign b_err_o   = b_err_q;
    assign b_rdata_o = b_rdata_q;

endmodule
